// File: rtl/decode_queue_mw.sv
// Multi-issue decode queue between fetch and decode: circular buffer of {instr, pc}
// with multi-lane enqueue, show-ahead multi-lane dispatch, flush and serialize mode.
module decode_queue_mw #(
    parameter int DEPTH = 16,
    parameter int IN_W  = 2,
    parameter int OUT_W = 2,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                FLUSH,
    input  logic                SYS,
    input  logic                STALL_IN_IF,
    input  logic                STALL_IN_ID,
    input  logic [IN_W-1:0]     IN_VALID,
    input  logic [32*IN_W-1:0]  Instr_IN,
    input  logic [32*IN_W-1:0]  Instr_PC_IN,
    output logic [32*OUT_W-1:0] Instr_OUT,
    output logic [32*OUT_W-1:0] Instr_PC_OUT,
    output logic [OUT_W-1:0]    OUT_VALID,
    output logic                STALL_OUT_IF,
    output logic                STALL_OUT_ID,
    output logic [AW:0]         COUNT
);

    localparam int CW = AW + 1;

    logic [31:0]   instr_mem_q [DEPTH];
    logic [31:0]   pc_mem_q    [DEPTH];

    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q,  count_d;

    logic [CW-1:0] free_cnt;
    logic [CW-1:0] n_in;
    logic [CW-1:0] n_out;
    logic [CW-1:0] avail;
    logic          push;

    // Admission looks only at the occupancy at the start of the cycle.
    always_comb begin
        free_cnt     = CW'(DEPTH) - count_q;
        STALL_OUT_IF = (free_cnt < CW'(IN_W));
        STALL_OUT_ID = (count_q == '0);
        push         = ~FLUSH & ~STALL_IN_IF & ~STALL_OUT_IF;
    end

    always_comb begin
        n_in = '0;
        if (push) begin
            for (int i = 0; i < IN_W; i++) begin
                n_in = n_in + CW'(IN_VALID[i]);
            end
        end
    end

    always_comb begin
        if (SYS) begin
            avail = (count_q != '0) ? CW'(1) : '0;
        end else begin
            avail = (count_q < CW'(OUT_W)) ? count_q : CW'(OUT_W);
        end
        n_out = (STALL_IN_ID | FLUSH) ? '0 : avail;
    end

    always_comb begin
        if (FLUSH) begin
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            count_d  = count_q + n_in - n_out;
            wr_ptr_d = wr_ptr_q + n_in[AW-1:0];
            rd_ptr_d = rd_ptr_q + n_out[AW-1:0];
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage is not reset; occupancy gates everything that reaches the outputs.
    always_ff @(posedge CLK) begin
        for (int i = 0; i < IN_W; i++) begin
            if (push && IN_VALID[i]) begin
                instr_mem_q[wr_ptr_q + AW'(i)] <= Instr_IN[32*i +: 32];
                pc_mem_q[wr_ptr_q + AW'(i)]    <= Instr_PC_IN[32*i +: 32];
            end
        end
    end

    for (genvar j = 0; j < OUT_W; j++) begin : g_out
        logic          lane_vld;
        logic [AW-1:0] lane_idx;

        assign lane_vld  = (CW'(j) < avail);
        assign lane_idx  = rd_ptr_q + AW'(j);
        assign OUT_VALID[j]            = lane_vld;
        assign Instr_OUT[32*j +: 32]    = lane_vld ? instr_mem_q[lane_idx] : 32'h0;
        assign Instr_PC_OUT[32*j +: 32] = lane_vld ? pc_mem_q[lane_idx]    : 32'h0;
    end

    assign COUNT = count_q;

endmodule

// File: tb/tb_decode_queue_mw.sv
// Scoreboard bench for decode_queue_mw: driver pushes accepted instructions into a
// reference queue, a negedge monitor compares every presented lane and the status outputs.
module tb_decode_queue_mw;

    localparam int DEPTH = 16;
    localparam int IN_W  = 2;
    localparam int OUT_W = 2;
    localparam int AW    = $clog2(DEPTH);

    logic                CLK;
    logic                RESET;
    logic                FLUSH;
    logic                SYS;
    logic                STALL_IN_IF;
    logic                STALL_IN_ID;
    logic [IN_W-1:0]     IN_VALID;
    logic [32*IN_W-1:0]  Instr_IN;
    logic [32*IN_W-1:0]  Instr_PC_IN;
    logic [32*OUT_W-1:0] Instr_OUT;
    logic [32*OUT_W-1:0] Instr_PC_OUT;
    logic [OUT_W-1:0]    OUT_VALID;
    logic                STALL_OUT_IF;
    logic                STALL_OUT_ID;
    logic [AW:0]         COUNT;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } ent_t;

    ent_t        exp_q[$];
    int          n_vec = 0;
    int          n_err = 0;
    int unsigned next_pc = 0;

    decode_queue_mw #(.DEPTH(DEPTH), .IN_W(IN_W), .OUT_W(OUT_W)) dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .FLUSH        (FLUSH),
        .SYS          (SYS),
        .STALL_IN_IF  (STALL_IN_IF),
        .STALL_IN_ID  (STALL_IN_ID),
        .IN_VALID     (IN_VALID),
        .Instr_IN     (Instr_IN),
        .Instr_PC_IN  (Instr_PC_IN),
        .Instr_OUT    (Instr_OUT),
        .Instr_PC_OUT (Instr_PC_OUT),
        .OUT_VALID    (OUT_VALID),
        .STALL_OUT_IF (STALL_OUT_IF),
        .STALL_OUT_ID (STALL_OUT_ID),
        .COUNT        (COUNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge CLK) begin
        if (RESET) begin
            assert ((IN_VALID & (IN_VALID + 1'b1)) == '0)
                else $error("IN_VALID not thermometer: %b", IN_VALID);
        end
    end

    // Monitor: the reference queue head is what lane 0 must show.
    always @(negedge CLK) begin
        int sz;
        int av;
        sz = exp_q.size();
        if (SYS) av = (sz > 0) ? 1 : 0;
        else     av = (sz < OUT_W) ? sz : OUT_W;
        chk("count", 64'(COUNT), 64'(sz));
        chk("stall_out_id", 64'(STALL_OUT_ID), 64'(sz == 0));
        chk("stall_out_if", 64'(STALL_OUT_IF), 64'((DEPTH - sz) < IN_W));
        for (int j = 0; j < OUT_W; j++) begin
            if (j < av) begin
                chk($sformatf("valid%0d", j), 64'(OUT_VALID[j]), 64'(1));
                chk($sformatf("instr%0d", j), 64'(Instr_OUT[32*j +: 32]), 64'(exp_q[j].instr));
                chk($sformatf("pc%0d", j), 64'(Instr_PC_OUT[32*j +: 32]), 64'(exp_q[j].pc));
            end else begin
                chk($sformatf("valid%0d", j), 64'(OUT_VALID[j]), 64'(0));
                chk($sformatf("instr%0d_zero", j), 64'(Instr_OUT[32*j +: 32]), 64'(0));
                chk($sformatf("pc%0d_zero", j), 64'(Instr_PC_OUT[32*j +: 32]), 64'(0));
            end
        end
        if (RESET && !FLUSH && !STALL_IN_ID) begin
            repeat (av) void'(exp_q.pop_front());
        end
    end

    // Called just after a rising edge; returns just after the next one.
    task automatic step(input int nl, input bit stall_if, input bit stall_id,
                        input bit sys, input bit flush);
        ent_t pend[$];
        ent_t e;
        bit   acc;
        IN_VALID    = '0;
        Instr_IN    = '0;
        Instr_PC_IN = '0;
        for (int i = 0; i < IN_W; i++) begin
            if (i < nl) begin
                e.instr = $urandom;
                e.pc    = next_pc + 4 * i;
                IN_VALID[i]              = 1'b1;
                Instr_IN[32*i +: 32]     = e.instr;
                Instr_PC_IN[32*i +: 32]  = e.pc;
                pend.push_back(e);
            end
        end
        STALL_IN_IF = stall_if;
        STALL_IN_ID = stall_id;
        SYS         = sys;
        FLUSH       = flush;
        acc = !flush && !stall_if && ((DEPTH - exp_q.size()) >= IN_W);
        @(posedge CLK);
        if (flush) exp_q.delete();
        else if (acc) foreach (pend[k]) exp_q.push_back(pend[k]);
        if (acc || flush) next_pc += 4 * nl;
        #1;
    endtask

    task automatic async_reset();
        IN_VALID    = '0;
        STALL_IN_IF = 1'b0;
        STALL_IN_ID = 1'b1;
        SYS         = 1'b0;
        FLUSH       = 1'b0;
        #2;
        RESET = 1'b0;
        #1;
        chk("async_count", 64'(COUNT), 64'(0));
        chk("async_valid", 64'(OUT_VALID), 64'(0));
        chk("async_stall_id", 64'(STALL_OUT_ID), 64'(1));
        exp_q.delete();
        @(posedge CLK);
        @(posedge CLK);
        #1;
        RESET = 1'b1;
    endtask

    initial begin
        RESET       = 1'b0;
        FLUSH       = 1'b0;
        SYS         = 1'b0;
        STALL_IN_IF = 1'b0;
        STALL_IN_ID = 1'b0;
        IN_VALID    = '0;
        Instr_IN    = '0;
        Instr_PC_IN = '0;
        repeat (3) @(posedge CLK);
        #1;
        RESET = 1'b1;
        repeat (2) step(0, 0, 0, 0, 0);

        // fill to full, ninth push refused
        repeat (9) step(2, 0, 1, 0, 0);
        repeat (8) step(0, 0, 0, 0, 0);

        // streaming at occupancy 3 across the pointer wrap
        step(2, 0, 1, 0, 0);
        step(1, 0, 1, 0, 0);
        repeat (40) step(2, 0, 0, 0, 0);

        // serialize from 6 down to 3, then wide again
        step(2, 0, 1, 0, 0);
        step(1, 0, 1, 0, 0);
        repeat (3) step(0, 0, 0, 1, 0);
        step(0, 0, 1, 0, 0);

        // flush with simultaneous push and pop at occupancy 5
        step(2, 0, 1, 0, 0);
        step(2, 0, 0, 0, 1);
        repeat (2) step(0, 0, 1, 0, 0);

        // asynchronous reset at occupancy 9
        repeat (4) step(2, 0, 1, 0, 0);
        step(1, 0, 1, 0, 0);
        async_reset();
        step(1, 0, 1, 0, 0);
        step(0, 0, 1, 0, 0);
        repeat (4) step(0, 0, 0, 0, 0);

        repeat (400) begin
            step($urandom_range(0, IN_W),
                 $urandom_range(0, 3) == 0,
                 $urandom_range(0, 2) == 0,
                 $urandom_range(0, 4) == 0,
                 $urandom_range(0, 30) == 0);
        end

        @(negedge CLK);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/decode_queue_mw.md
# decode_queue_mw

Parametrised multi-issue decode queue between instruction fetch (IF) and instruction decode (ID). Accepts up to IN_W instructions with their PCs per cycle from IF and presents up to OUT_W oldest instructions per cycle to ID, in program order. It adds three behaviours the single-wide queue lacks:
- a flush that discards all contents (branch mispredict, exception);
- a serialize mode that dispatches one instruction per cycle while SYS is high;
- an occupancy count output.

## Interface
Parameters:
- DEPTH, 16, queue entries; power of 2, ≥ 2·max(IN_W, OUT_W)
- IN_W, 2, instruction lanes from IF per cycle (1..4)
- OUT_W, 2, instruction lanes to ID per cycle (1..4)
- AW, $clog2(DEPTH), pointer width (derived, do not override)

Ports:
- CLK  in  1  clock, rising edge
- RESET  in  1  asynchronous, active-low reset
- FLUSH  in  1  synchronous discard of all entries
- SYS  in  1  serialize mode: at most one instruction dispatched per cycle
- STALL_IN_IF  in  1  IF has nothing valid this cycle; inhibits enqueue
- STALL_IN_ID  in  1  ID cannot accept this cycle; inhibits dequeue
- IN_VALID  in  IN_W  lane valids; must be contiguous from lane 0 (thermometer)
- Instr_IN  in  32·IN_W  instructions; lane i = bits [32i+31:32i], lane 0 oldest
- Instr_PC_IN  in  32·IN_W  PCs, same packing
- Instr_OUT  out  32·OUT_W  instructions; lane 0 = queue head
- Instr_PC_OUT  out  32·OUT_W  PCs, same packing
- OUT_VALID  out  OUT_W  presented-lane valids, thermometer from lane 0
- STALL_OUT_IF  out  1  fewer than IN_W free entries; IF must hold
- STALL_OUT_ID  out  1  queue empty
- COUNT  out  AW+1  current occupancy, 0..DEPTH

## Operation
- State: circular buffer of DEPTH {instr, pc} entries; head pointer rd_ptr and tail pointer wr_ptr, each AW bits, wrap modulo DEPTH; count register AW+1 bits.
- Enqueue:
  - push = IN_VALID & ~STALL_IN_IF & ~STALL_OUT_IF.
  - When active, lane i writes entry (wr_ptr+i) mod DEPTH for each valid lane.
  - n_in = popcount(IN_VALID) entries are added.
  - IN_VALID lanes are ignored while STALL_IN_IF or STALL_OUT_IF is high.
- Presentation (show-ahead, combinational from registered state):
  - avail = min(count, OUT_W), forced to min(count, 1) when SYS = 1.
  - OUT_VALID[j] = (j < avail).
  - Lane j shows entry (rd_ptr+j) mod DEPTH.
  - Invalid lanes drive 0.
- Dequeue: when STALL_IN_ID = 0, all avail presented instructions are consumed at the clock edge (n_out = avail). No partial acceptance.
- Update: count ← count + n_in − n_out; wr_ptr += n_in; rd_ptr += n_out.
  - Enqueue and dequeue in the same cycle are both honoured.
  - Enqueue admission uses count at the start of the cycle; same-cycle frees do not unblock IF.
- STALL_OUT_IF = (DEPTH − count < IN_W). STALL_OUT_ID = (count == 0).
- FLUSH = 1 takes priority over enqueue and dequeue. At the edge: count, rd_ptr and wr_ptr ← 0. Input lanes in that cycle are dropped. Storage contents are don't-care.
- SYS changes take effect combinationally in the same cycle; the dispatch width is re-evaluated every cycle.
- Illegal input: non-thermometer IN_VALID. Behaviour undefined; the bench flags it with an assertion.

## Timing
- While RESET is low, regardless of clock:
  - count, rd_ptr, wr_ptr = 0
  - OUT_VALID = 0; Instr_OUT, Instr_PC_OUT = 0
  - STALL_OUT_ID = 1; STALL_OUT_IF = 0 (DEPTH ≥ IN_W); COUNT = 0
- Reset asserted mid-operation discards all entries immediately. The first enqueue can occur on the first rising edge after RESET deasserts.
- Enqueue-to-visible latency is 1 cycle: an instruction written at edge k appears on Instr_OUT lane 0 after edge k if the queue was empty. There is no fall-through bypass.
- Full to not-full: one dequeue edge, then STALL_OUT_IF falls in that same post-edge cycle.
- Wrap-around: pointer arithmetic is modulo DEPTH. Multi-lane writes and reads that straddle entry DEPTH−1 → 0 must be contiguous and correct.
- Throughput: sustained min(IN_W, OUT_W) instructions/cycle with no bubbles when neither side stalls. Drops to 1/cycle while SYS = 1.

## Test plan
- Reset/idle: hold RESET low for 3 cycles, then release with no input → COUNT = 0, STALL_OUT_ID = 1, STALL_OUT_IF = 0, OUT_VALID = 0 throughout.
- Fill/full (IN_W = 2, DEPTH = 16, STALL_IN_ID = 1): push 2 per cycle with PCs 0x0, 0x4, … → COUNT reaches 16 after 8 edges and STALL_OUT_IF = 1. A ninth push is ignored and COUNT stays 16.
- Streaming plus wrap-around: push 2 and pop 2 per cycle for 40 cycles starting from COUNT = 3 → COUNT stays 3. Output PCs are strictly sequential across the 15→0 pointer wrap, with no loss or duplication.
- Serialize mode: COUNT = 6 with SYS = 1 and no push → exactly one instruction leaves per edge, OUT_VALID = 01. Dropping SYS at COUNT = 3 → next cycle shows OUT_VALID = 11.
- Flush with simultaneous push/pop: COUNT = 5, IN_VALID = 11, STALL_IN_ID = 0, FLUSH = 1 → next cycle COUNT = 0, STALL_OUT_ID = 1, and none of the pushed PCs ever appear.
- Asynchronous reset mid-stream: drive RESET low between edges while COUNT = 9 → COUNT and OUT_VALID go to 0 without a clock edge. After release, the first pushed PC appears at lane 0 one cycle later.
